operand_stage: RTL and testbench

Decode-to-execute pipeline stage of the 16-bit, 8-register pipelined core, directly downstream of the register file. It captures register-file read data plus decode control into the ID/EX pipeline register. Operands are forwarded from the EX, MEM and WB stages to cover register-file write latency. It detects load-use hazards, holding the front end and inserting one bubble per hazard, and applies branch flushes.

---
 rtl/operand_stage.sv | 148 ++++++++++++++
 tb/tb_operand_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_stage.sv
// ID/EX pipeline register with operand forwarding, load-use hazard stall and branch flush.
// A two-state FSM inserts exactly one bubble per load-use hazard.
module operand_stage #(
  parameter int unsigned DW  = 16,
  parameter int unsigned AW  = 3,
  parameter int unsigned CW  = 8,
  parameter int unsigned SCW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           id_valid,
  input  logic [AW-1:0]  id_rs1,
  input  logic [AW-1:0]  id_rs2,
  input  logic [AW-1:0]  id_rd,
  input  logic           id_regwrite,
  input  logic           id_memread,
  input  logic [CW-1:0]  id_ctrl,
  input  logic [DW-1:0]  id_imm,
  input  logic [DW-1:0]  rf_data1,
  input  logic [DW-1:0]  rf_data2,
  input  logic [DW-1:0]  alu_result,
  input  logic [AW-1:0]  mem_rd,
  input  logic           mem_regwrite,
  input  logic [DW-1:0]  mem_data,
  input  logic [AW-1:0]  wb_rd,
  input  logic           wb_regwrite,
  input  logic [DW-1:0]  wb_data,
  input  logic           flush,
  output logic           stall,
  output logic           ex_valid,
  output logic           ex_regwrite,
  output logic           ex_memread,
  output logic [AW-1:0]  ex_rd,
  output logic [CW-1:0]  ex_ctrl,
  output logic [DW-1:0]  ex_imm,
  output logic [DW-1:0]  ex_op1,
  output logic [DW-1:0]  ex_op2,
  output logic [SCW-1:0] stall_count
);

  typedef enum logic [0:0] {StRun, StBubble} state_e;

  state_e        state_q, state_d;
  logic          hz;
  logic          capture_bubble;
  logic          ex_fwd_ok;
  logic [DW-1:0] op1_fwd, op2_fwd;

  // A load in EX has no result yet, so it never forwards from alu_result.
  assign ex_fwd_ok = ex_valid & ex_regwrite & ~ex_memread;

  function automatic logic [DW-1:0] fwd_sel(
    input logic [AW-1:0] rs,
    input logic [DW-1:0] rf,
    input logic          ex_ok,
    input logic [AW-1:0] ex_dst,
    input logic [DW-1:0] alu,
    input logic          mem_we,
    input logic [AW-1:0] mem_dst,
    input logic [DW-1:0] mem_val,
    input logic          wb_we,
    input logic [AW-1:0] wb_dst,
    input logic [DW-1:0] wb_val
  );
    if (rs == '0)                         return '0;
    else if (ex_ok && ex_dst == rs)       return alu;
    else if (mem_we && mem_dst == rs)     return mem_val;
    else if (wb_we && wb_dst == rs)       return wb_val;
    else                                  return rf;
  endfunction

  always_comb begin
    op1_fwd = fwd_sel(id_rs1, rf_data1, ex_fwd_ok, ex_rd, alu_result, mem_regwrite, mem_rd,
                      mem_data, wb_regwrite, wb_rd, wb_data);
    op2_fwd = fwd_sel(id_rs2, rf_data2, ex_fwd_ok, ex_rd, alu_result, mem_regwrite, mem_rd,
                      mem_data, wb_regwrite, wb_rd, wb_data);
  end

  assign hz    = id_valid & ex_valid & ex_memread & (ex_rd != '0) &
                 ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign stall = hz & ~flush;

  always_comb begin
    state_d        = state_q;
    capture_bubble = 1'b0;
    unique case (state_q)
      StRun: begin
        if (flush || hz) begin
          capture_bubble = 1'b1;
          state_d        = (hz && !flush) ? StBubble : StRun;
        end
      end
      StBubble: begin
        state_d = StRun;
        if (flush) capture_bubble = 1'b1;
      end
    endcase
    if (!id_valid) capture_bubble = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_rd       <= '0;
      ex_ctrl     <= '0;
      ex_imm      <= '0;
      ex_op1      <= '0;
      ex_op2      <= '0;
    end else if (capture_bubble) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_rd       <= '0;
      ex_ctrl     <= '0;
      ex_imm      <= '0;
      ex_op1      <= '0;
      ex_op2      <= '0;
    end else begin
      ex_valid    <= 1'b1;
      ex_regwrite <= id_regwrite;
      ex_memread  <= id_memread;
      ex_rd       <= id_rd;
      ex_ctrl     <= id_ctrl;
      ex_imm      <= id_imm;
      ex_op1      <= op1_fwd;
      ex_op2      <= op2_fwd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {SCW{1'b1}})) begin
      stall_count <= stall_count + SCW'(1);
    end
  end

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: per-cycle comparison against a behavioural model,
// plus directed vectors with hand-computed expectations.
module tb_operand_stage;

  logic        clk, rst_n;
  logic        id_valid, id_regwrite, id_memread, flush;
  logic [2:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
  logic [7:0]  id_ctrl;
  logic [15:0] id_imm, rf_data1, rf_data2, alu_result, mem_data, wb_data;
  logic        mem_regwrite, wb_regwrite;

  logic        stall, ex_valid, ex_regwrite, ex_memread;
  logic [2:0]  ex_rd;
  logic [7:0]  ex_ctrl;
  logic [15:0] ex_imm, ex_op1, ex_op2, stall_count;

  logic        s_stall, s_valid, s_regwrite, s_memread;
  logic [2:0]  s_rd;
  logic [7:0]  s_ctrl;
  logic [15:0] s_imm, s_op1, s_op2;
  logic [3:0]  s_count;

  int total = 0;
  int bad   = 0;

  operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_ctrl(id_ctrl),
    .id_imm(id_imm), .rf_data1(rf_data1), .rf_data2(rf_data2), .alu_result(alu_result),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_data(mem_data), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .wb_data(wb_data), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .ex_imm(ex_imm), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .stall_count(stall_count)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  operand_stage #(.SCW(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_ctrl(id_ctrl),
    .id_imm(id_imm), .rf_data1(rf_data1), .rf_data2(rf_data2), .alu_result(alu_result),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_data(mem_data), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .wb_data(wb_data), .flush(flush), .stall(s_stall),
    .ex_valid(s_valid), .ex_regwrite(s_regwrite), .ex_memread(s_memread), .ex_rd(s_rd),
    .ex_ctrl(s_ctrl), .ex_imm(s_imm), .ex_op1(s_op1), .ex_op2(s_op2),
    .stall_count(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        v, rw, mr;
    logic [2:0]  rd;
    logic [7:0]  ctrl;
    logic [15:0] imm, op1, op2;
  } ex_t;

  ex_t         m_ex;
  logic [15:0] m_cnt;
  logic [3:0]  m_cnt_s;
  logic        m_hz, m_stall;

  // Value an instruction in decode should see for register rs right now.
  function automatic logic [15:0] m_read(input logic [2:0] rs, input logic [15:0] rf);
    logic [15:0] r;
    r = rf;
    if (wb_regwrite && wb_rd == rs) r = wb_data;
    if (mem_regwrite && mem_rd == rs) r = mem_data;
    if (m_ex.v && m_ex.rw && !m_ex.mr && m_ex.rd == rs) r = alu_result;
    if (rs == 3'd0) r = 16'd0;
    return r;
  endfunction

  always_comb begin
    m_hz    = id_valid && m_ex.v && m_ex.mr && m_ex.rd != 3'd0 &&
              (m_ex.rd == id_rs1 || m_ex.rd == id_rs2);
    m_stall = m_hz && !flush;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex    <= '0;
      m_cnt   <= 16'd0;
      m_cnt_s <= 4'd0;
    end else begin
      if (m_stall) begin
        m_cnt   <= (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
        m_cnt_s <= (m_cnt_s == 4'hF) ? m_cnt_s : m_cnt_s + 4'd1;
      end
      if (flush || m_hz || !id_valid) m_ex <= '0;
      else m_ex <= '{v: 1'b1, rw: id_regwrite, mr: id_memread, rd: id_rd, ctrl: id_ctrl,
                     imm: id_imm, op1: m_read(id_rs1, rf_data1), op2: m_read(id_rs2, rf_data2)};
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_stall", {31'd0, stall}, {31'd0, m_stall});
      chk("cmp_ex_ctl", {ex_valid, ex_regwrite, ex_memread, ex_rd, ex_ctrl},
          {m_ex.v, m_ex.rw, m_ex.mr, m_ex.rd, m_ex.ctrl});
      chk("cmp_ex_imm", {16'd0, ex_imm}, {16'd0, m_ex.imm});
      chk("cmp_ex_ops", {ex_op1, ex_op2}, {m_ex.op1, m_ex.op2});
      chk("cmp_count", {16'd0, stall_count}, {16'd0, m_cnt});
      chk("cmp_sat_count", {28'd0, s_count}, {28'd0, m_cnt_s});
      chk("cmp_sat_stall", {31'd0, s_stall}, {31'd0, m_stall});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                       input logic rw, input logic mr, input logic [15:0] r1,
                       input logic [15:0] r2);
    id_valid    = 1'b1;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    id_ctrl     = {2'b10, rd, rs1};
    id_imm      = {8'hA0, 2'b00, rd, rs2};
    rf_data1    = r1;
    rf_data2    = r2;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_regwrite = 1'b0;
    id_memread = 1'b0; id_ctrl = '0; id_imm = '0; rf_data1 = '0; rf_data2 = '0;
    alu_result = '0; mem_rd = '0; mem_regwrite = 1'b0; mem_data = '0;
    wb_rd = '0; wb_regwrite = 1'b0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_ex_op1", {16'd0, ex_op1}, 32'd0);
    chk("reset_count", {16'd0, stall_count}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;

    // Back-to-back ALU: add r3,r1,r1 then add r4,r3,r1
    instr(3'd1, 3'd1, 3'd3, 1'b1, 1'b0, 16'd10, 16'd10);
    cyc();
    chk("b2b_first_op1", {16'd0, ex_op1}, 32'd10);
    instr(3'd3, 3'd1, 3'd4, 1'b1, 1'b0, 16'd7, 16'd10);
    alu_result = 16'd20;
    #1 chk("b2b_no_stall", {31'd0, stall}, 32'd0);
    cyc();
    chk("b2b_ex_fwd", {16'd0, ex_op1}, 32'd20);
    chk("b2b_op2", {16'd0, ex_op2}, 32'd10);

    // Load-use: lw r2 then add r6,r2,r1
    instr(3'd1, 3'd0, 3'd2, 1'b1, 1'b1, 16'd10, 16'd0);
    cyc();
    instr(3'd2, 3'd1, 3'd6, 1'b1, 1'b0, 16'h0BAD, 16'd10);
    alu_result = 16'd14;
    #1 chk("lu_stall", {31'd0, stall}, 32'd1);
    cyc();
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    mem_regwrite = 1'b1; mem_rd = 3'd2; mem_data = 16'h1234;
    #1 chk("lu_stall_one_cycle", {31'd0, stall}, 32'd0);
    cyc();
    chk("lu_mem_fwd", {16'd0, ex_op1}, 32'h1234);
    chk("lu_rd", {29'd0, ex_rd}, 32'd6);
    chk("lu_count", {16'd0, stall_count}, 32'd1);
    mem_regwrite = 1'b0;

    // WB bypass
    instr(3'd5, 3'd0, 3'd1, 1'b1, 1'b0, 16'd50, 16'd0);
    wb_regwrite = 1'b1; wb_rd = 3'd5; wb_data = 16'hBEEF;
    cyc();
    chk("wb_bypass", {16'd0, ex_op1}, 32'hBEEF);
    wb_regwrite = 1'b0;

    // r0 guard
    instr(3'd0, 3'd0, 3'd1, 1'b1, 1'b0, 16'h0055, 16'h0055);
    mem_regwrite = 1'b1; mem_rd = 3'd0; mem_data = 16'hFFFF;
    cyc();
    chk("r0_guard", {16'd0, ex_op1}, 32'd0);
    mem_regwrite = 1'b0;
    instr(3'd1, 3'd0, 3'd0, 1'b1, 1'b1, 16'd10, 16'd0);
    cyc();
    instr(3'd0, 3'd0, 3'd3, 1'b1, 1'b0, 16'd0, 16'd0);
    #1 chk("r0_load_no_stall", {31'd0, stall}, 32'd0);
    cyc();
    chk("r0_load_valid", {31'd0, ex_valid}, 32'd1);

    // Priority: EX beats MEM/WB, then MEM beats WB
    alu_result = 16'h0AAA;
    instr(3'd3, 3'd3, 3'd7, 1'b1, 1'b0, 16'd1, 16'd2);
    mem_regwrite = 1'b1; mem_rd = 3'd3; mem_data = 16'h4444;
    wb_regwrite = 1'b1; wb_rd = 3'd3; wb_data = 16'h3333;
    cyc();
    chk("prio_ex", {ex_op1, ex_op2}, 32'h0AAA_0AAA);
    instr(3'd3, 3'd0, 3'd1, 1'b1, 1'b0, 16'd1, 16'd0);
    cyc();
    chk("prio_mem", {16'd0, ex_op1}, 32'h4444);
    mem_regwrite = 1'b0; wb_regwrite = 1'b0;

    // Flush and hazard together
    instr(3'd1, 3'd0, 3'd2, 1'b1, 1'b1, 16'd10, 16'd0);
    cyc();
    instr(3'd0, 3'd2, 3'd4, 1'b1, 1'b0, 16'd0, 16'd9);
    flush = 1'b1;
    #1 chk("flush_hz_stall", {31'd0, stall}, 32'd0);
    cyc();
    chk("flush_hz_bubble", {31'd0, ex_valid}, 32'd0);
    chk("flush_hz_count", {16'd0, stall_count}, 32'd1);
    flush = 1'b0;

    // Flush during bubble
    instr(3'd1, 3'd0, 3'd2, 1'b1, 1'b1, 16'd10, 16'd0);
    cyc();
    instr(3'd2, 3'd0, 3'd4, 1'b1, 1'b0, 16'd0, 16'd0);
    #1 chk("fb_stall", {31'd0, stall}, 32'd1);
    cyc();
    flush = 1'b1;
    #1 chk("fb_flush_stall", {31'd0, stall}, 32'd0);
    cyc();
    chk("fb_bubble", {31'd0, ex_valid}, 32'd0);
    chk("fb_count", {16'd0, stall_count}, 32'd2);
    flush = 1'b0;
    instr(3'd1, 3'd1, 3'd4, 1'b1, 1'b0, 16'd10, 16'd10);
    cyc();
    chk("fb_resume", {31'd0, ex_valid}, 32'd1);

    // Asynchronous reset mid-bubble
    instr(3'd1, 3'd0, 3'd2, 1'b1, 1'b1, 16'd10, 16'd0);
    cyc();
    instr(3'd2, 3'd0, 3'd5, 1'b1, 1'b0, 16'h0777, 16'd0);
    cyc();
    chk("rst_pre_count", {16'd0, stall_count}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_count", {16'd0, stall_count}, 32'd0);
    chk("rst_async_ex", {ex_valid, ex_rd, ex_op1}, 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("rst_recapture", {15'd0, ex_valid, ex_op1}, 32'h0001_0777);

    // Saturation: repeated lw r2,(r2) back to back
    instr(3'd1, 3'd0, 3'd2, 1'b1, 1'b1, 16'd10, 16'd0);
    cyc();
    for (int i = 0; i < 20; i++) begin
      instr(3'd2, 3'd0, 3'd2, 1'b1, 1'b1, 16'd0, 16'd0);
      cyc();
      cyc();
    end
    id_valid = 1'b0;
    cyc();
    chk("sat_count_small", {28'd0, s_count}, 32'hF);
    chk("sat_count_wide", {16'd0, stall_count}, 32'd20);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
